bcd_timer: RTL and testbench
============================

BCD_TIMER -- requirements
Module: bcd_timer

Interface
REQ-001 SHALL have parameter DIGITS, default 2; number of BCD digits, legal range 1..6.
REQ-002 SHALL have parameter INIT_VAL, default 12 in packed BCD; value loaded by reset.
REQ-003 SHALL have parameter WRAP, default 0; 0 = stop at terminal, 1 = wrap and keep running.
REQ-004 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-005 SHALL have port resetN, input, 1 bit; reset, asynchronous, active-low.
REQ-006 SHALL have port loadN, input, 1 bit; synchronous load, active-low.
REQ-007 SHALL have port load_data, input, 4*DIGITS bits; packed BCD load value, digit 0 in bits [3:0].
REQ-008 SHALL have port start, input, 1 bit; one-cycle request to begin counting.
REQ-009 SHALL have port tick, input, 1 bit; count-step strobe, nominally one cycle wide.
REQ-010 SHALL have port run_en, input, 1 bit; pause control, low freezes counting.
REQ-011 SHALL have port dir, input, 1 bit; 0 = count down, 1 = count up.
REQ-012 SHALL have port count, output, 4*DIGITS bits; registered packed BCD value.
REQ-013 SHALL have port tc, output, 1 bit; combinational, high while count equals the terminal value for the current dir.
REQ-014 SHALL have port done_pulse, output, 1 bit; registered, one cycle wide.
REQ-015 SHALL have port running, output, 1 bit; high while the state is RUN.

Function
REQ-016 SHALL use three states: IDLE, RUN, DONE.
REQ-017 SHALL define the terminal value as all digits 0 when dir=0, and all digits 9 when dir=1.
REQ-018 SHALL, when loadN=0, load load_data into count and enter IDLE regardless of state; loadN has priority over start and tick.
REQ-019 SHALL saturate any load_data nibble above 9 to 9 on load.
REQ-020 SHALL move IDLE to RUN on start=1; start in RUN or DONE SHALL be ignored.
REQ-021 SHALL, in RUN, step count by one per cycle with tick=1 and run_en=1, propagating borrow or carry digit-to-digit within the same cycle.
REQ-022 SHALL, in RUN with WRAP=0, enter DONE and assert done_pulse in the cycle count becomes terminal; further ticks SHALL leave count unchanged.
REQ-023 SHALL, in RUN with WRAP=0 and count already terminal at entry, enter DONE on the next clock without stepping.
REQ-024 SHALL, with WRAP=1, wrap 0..0 to 9..9 (down) or 9..9 to 0..0 (up), stay in RUN, and assert done_pulse each time the terminal value is reached.
REQ-025 SHALL allow dir to change in any state; tc and the next step follow the new dir immediately.
REQ-026 SHALL hold count unchanged in IDLE and DONE.

Reset
REQ-027 SHALL, on resetN=0, asynchronously set count=INIT_VAL, state=IDLE, done_pulse=0, running=0.
REQ-028 SHALL, on reset mid-count, abandon the count with no done_pulse generated.

Configuration
REQ-029 SHALL, with macro BCD_TIMER_WARN_EN defined, add parameter WARN_VAL (default 3, packed BCD) and a registered output warn, high in RUN while count<=WARN_VAL (dir=0) or count>=WARN_VAL (dir=1), 0 at reset.
REQ-030 SHALL, without BCD_TIMER_WARN_EN, omit WARN_VAL, the warn port and all associated logic.

Structure
REQ-031 SHALL place the state enum typedef, a bcd_digit_t typedef (4 bits), and constants BCD_MAX=9 and BCD_MIN=0 in package bcd_timer_pkg.
REQ-032 SHALL implement each digit as sub-module bcd_digit_cell (dir, step-in, load, borrow/carry-out, count), instantiated DIGITS times by generate.

Verification
REQ-033 SHALL cover: DIGITS=2, reset -> count=12; start, 12 ticks -> count=00, done_pulse once, state DONE, 13th tick leaves 00.
REQ-034 SHALL cover: load 40, start, dir=0, one tick -> 39 (borrow across digits); dir=1 then one tick -> 40.
REQ-035 SHALL cover: WRAP=1, load 01, start, 2 ticks -> 00 then 99, done_pulse on 00 only, running stays 1.
REQ-036 SHALL cover: run_en=0 during 5 ticks -> count frozen; loadN=0 together with tick in RUN -> load wins, state IDLE.
REQ-037 SHALL cover: load 0xA5 -> count=95; resetN pulsed low mid-RUN -> count=12, running=0, no done_pulse.
REQ-038 SHALL cover, with BCD_TIMER_WARN_EN: WARN_VAL=03, count down from 05 -> warn rises on the cycle after count=03.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared types, FSM encoding and digit helpers for the BCD timer.
package bcd_timer_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_RUN  = 2'd1,
        STATE_DONE = 2'd2
    } state_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Non-decimal nibbles are clamped so the counter never holds an illegal digit.
    function automatic bcd_digit_t bcd_sat(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_timer_digit_cell.sv
// One decimal digit of the timer: holds its value and ripples borrow/carry upward.
module bcd_digit_cell
    import bcd_timer_pkg::*;
#(
    parameter logic [3:0] INIT = 4'd0
)(
    input  logic       clk,
    input  logic       resetN,
    input  logic       dir,
    input  logic       step_in,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       carry_out,
    output logic [3:0] count
);

    logic at_edge;

    // At the edge digit a step rolls over and passes the step to the next digit.
    assign at_edge   = dir ? (count == BCD_MAX) : (count == BCD_MIN);
    assign carry_out = step_in && at_edge;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= INIT;
        end else if (load) begin
            count <= bcd_sat(load_val);
        end else if (step_in) begin
            if (at_edge)
                count <= dir ? BCD_MIN : BCD_MAX;
            else if (dir)
                count <= count + 4'd1;
            else
                count <= count - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_timer.sv
// Multi-digit BCD up/down timer with IDLE/RUN/DONE control.
// Optional macro BCD_TIMER_WARN_EN adds WARN_VAL and a registered warn output.
module bcd_timer
    import bcd_timer_pkg::*;
#(
    parameter int                  DIGITS   = 2,
    parameter logic [4*DIGITS-1:0] INIT_VAL = 'h12,
    parameter int                  WRAP     = 0
`ifdef BCD_TIMER_WARN_EN
    ,
    parameter logic [4*DIGITS-1:0] WARN_VAL = 'h03
`endif
)(
    input  logic                clk,
    input  logic                resetN,
    input  logic                loadN,
    input  logic [4*DIGITS-1:0] load_data,
    input  logic                start,
    input  logic                tick,
    input  logic                run_en,
    input  logic                dir,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                done_pulse,
    output logic                running
`ifdef BCD_TIMER_WARN_EN
    ,
    output logic                warn
`endif
);

    localparam logic [1:0] IDLE = STATE_IDLE;
    localparam logic [1:0] RUN  = STATE_RUN;
    localparam logic [1:0] DONE = STATE_DONE;

    logic [1:0]          state;
    logic [4*DIGITS-1:0] term_val;
    logic [4*DIGITS-1:0] pre_term;
    logic                at_term;
    logic                near_term;
    logic                step_en;
    logic [DIGITS-1:0]   step_in;
    logic [DIGITS-1:0]   carry_out;
    logic                unused_carry;

    // pre_term is the value one step short of terminal, so reaching terminal is known a cycle early.
    always_comb begin
        term_val = '0;
        pre_term = '0;
        for (int i = 0; i < DIGITS; i++) begin
            term_val[4*i +: 4] = dir ? BCD_MAX : BCD_MIN;
            pre_term[4*i +: 4] = dir ? BCD_MAX : BCD_MIN;
        end
        pre_term[3:0] = dir ? (BCD_MAX - 4'd1) : (BCD_MIN + 4'd1);
    end

    assign at_term      = (count == term_val);
    assign near_term    = (count == pre_term);
    assign tc           = at_term;
    assign running      = (state == RUN);
    assign unused_carry = carry_out[DIGITS-1];

    assign step_en = (state == RUN) && tick && run_en && loadN
                     && !((WRAP == 0) && at_term);

    genvar gi;
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
        if (gi == 0) begin : g_first
            assign step_in[gi] = step_en;
        end else begin : g_next
            assign step_in[gi] = carry_out[gi-1];
        end

        bcd_digit_cell #(
            .INIT(INIT_VAL[4*gi +: 4])
        ) u_cell (
            .clk      (clk),
            .resetN   (resetN),
            .dir      (dir),
            .step_in  (step_in[gi]),
            .load     (!loadN),
            .load_val (load_data[4*gi +: 4]),
            .carry_out(carry_out[gi]),
            .count    (count[4*gi +: 4])
        );
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            done_pulse <= 1'b0;
        end else if (!loadN) begin
            state      <= IDLE;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= step_en && near_term;
            case (state)
                IDLE: if (start) state <= RUN;
                RUN:  if ((WRAP == 0) && (at_term || (step_en && near_term))) state <= DONE;
                DONE: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BCD_TIMER_WARN_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            warn <= 1'b0;
        else if (!loadN)
            warn <= 1'b0;
        else
            warn <= (state == RUN) && (dir ? (count >= WARN_VAL) : (count <= WARN_VAL));
    end
`endif

endmodule

// File: tb/tb_bcd_timer.sv
// Self-checking bench for bcd_timer: directed table, corner sequences, random run vs integer model.
`timescale 1ns/1ps
module tb_bcd_timer;

    logic       clk = 1'b0;
    logic       resetN, loadN, start, tick, run_en, dir;
    logic [7:0] load_data;
    logic [7:0] count0, count1;
    logic       tc0, tc1, dp0, dp1, run0, run1;
`ifdef BCD_TIMER_WARN_EN
    logic       warn0, warn1;
`endif

    int tests    = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_timer #(.DIGITS(2), .INIT_VAL(8'h12), .WRAP(0)) dut0 (
        .clk(clk), .resetN(resetN), .loadN(loadN), .load_data(load_data),
        .start(start), .tick(tick), .run_en(run_en), .dir(dir),
        .count(count0), .tc(tc0), .done_pulse(dp0), .running(run0)
`ifdef BCD_TIMER_WARN_EN
        , .warn(warn0)
`endif
    );

    bcd_timer #(.DIGITS(2), .INIT_VAL(8'h12), .WRAP(1)) dut1 (
        .clk(clk), .resetN(resetN), .loadN(loadN), .load_data(load_data),
        .start(start), .tick(tick), .run_en(run_en), .dir(dir),
        .count(count1), .tc(tc1), .done_pulse(dp1), .running(run1)
`ifdef BCD_TIMER_WARN_EN
        , .warn(warn1)
`endif
    );

    // Reference model: count as a plain integer 0..99, phase 0=idle 1=run 2=done.
    typedef struct {
        int v;
        int st;
        bit dp;
        bit warn;
    } model_t;

    model_t m [2];

    typedef struct {
        logic       loadN;
        logic [7:0] data;
        logic       start;
        logic       tick;
        logic       run_en;
        logic       dir;
        logic [7:0] exp_count;
        logic       exp_dp;
        logic       exp_run;
    } vec_t;

    vec_t vecs[$];

    function automatic int sat_load(input logic [7:0] d);
        int hi = int'(d[7:4]);
        int lo = int'(d[3:0]);
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] int_to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int terminal(input logic d);
        return d ? 99 : 0;
    endfunction

    function automatic model_t model_step(input model_t cur, input bit wrap);
        model_t nx = cur;
        nx.dp   = 1'b0;
        nx.warn = loadN && (cur.st == 1) && (dir ? (cur.v >= 3) : (cur.v <= 3));
        if (!loadN) begin
            nx.v  = sat_load(load_data);
            nx.st = 0;
            return nx;
        end
        case (cur.st)
            0: if (start) nx.st = 1;
            1: begin
                if (!wrap && cur.v == terminal(dir)) begin
                    nx.st = 2;
                end else if (tick && run_en) begin
                    nx.v  = dir ? (cur.v + 1) % 100 : (cur.v + 99) % 100;
                    nx.dp = (nx.v == terminal(dir));
                    if (!wrap && nx.dp) nx.st = 2;
                end
            end
            default: ;
        endcase
        return nx;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m[i].v = 12; m[i].st = 0; m[i].dp = 1'b0; m[i].warn = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic ld_n, input logic [7:0] data, input logic st,
                                 input logic tk, input logic en, input logic d);
        loadN = ld_n; load_data = data; start = st; tick = tk; run_en = en; dir = d;
    endtask

    task automatic checkOutput();
        check("count0",   32'(count0), 32'(int_to_bcd(m[0].v)));
        check("count1",   32'(count1), 32'(int_to_bcd(m[1].v)));
        check("tc0",      32'(tc0),    32'(m[0].v == terminal(dir)));
        check("tc1",      32'(tc1),    32'(m[1].v == terminal(dir)));
        check("done0",    32'(dp0),    32'(m[0].dp));
        check("done1",    32'(dp1),    32'(m[1].dp));
        check("running0", 32'(run0),   32'(m[0].st == 1));
        check("running1", 32'(run1),   32'(m[1].st == 1));
`ifdef BCD_TIMER_WARN_EN
        check("warn0",    32'(warn0),  32'(m[0].warn));
        check("warn1",    32'(warn1),  32'(m[1].warn));
`endif
    endtask

    task automatic step_clock();
        model_t nx0, nx1;
        nx0 = model_step(m[0], 1'b0);
        nx1 = model_step(m[1], 1'b1);
        @(posedge clk);
        #1;
        m[0] = nx0;
        m[1] = nx1;
        checkOutput();
    endtask

    task automatic add_vec(input logic ld_n, input logic [7:0] data, input logic st, input logic tk,
                           input logic en, input logic d, input logic [7:0] ec, input logic ed,
                           input logic er);
        vec_t v;
        v = '{ld_n, data, st, tk, en, d, ec, ed, er};
        vecs.push_back(v);
    endtask

    initial begin
        // Expected values here are for the stop-at-terminal instance.
        add_vec(1, 8'h00, 1, 0, 1, 0, 8'h12, 0, 1);
        for (int i = 0; i < 12; i++)
            add_vec(1, 8'h00, 0, 1, 1, 0, int_to_bcd(11 - i), (i == 11), (i != 11));
        add_vec(1, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);
        add_vec(0, 8'h40, 0, 0, 1, 0, 8'h40, 0, 0);
        add_vec(1, 8'h00, 1, 0, 1, 0, 8'h40, 0, 1);
        add_vec(1, 8'h00, 0, 1, 1, 0, 8'h39, 0, 1);
        add_vec(1, 8'h00, 0, 1, 1, 1, 8'h40, 0, 1);
        for (int i = 0; i < 5; i++)
            add_vec(1, 8'h00, 0, 1, 0, 1, 8'h40, 0, 1);
        add_vec(0, 8'h25, 0, 1, 1, 0, 8'h25, 0, 0);
        add_vec(0, 8'hA5, 0, 0, 1, 0, 8'h95, 0, 0);
        add_vec(1, 8'h00, 1, 0, 1, 0, 8'h95, 0, 1);
        add_vec(1, 8'h00, 0, 1, 1, 0, 8'h94, 0, 1);

        applyStimulus(1, 8'h00, 0, 0, 1, 0);
        resetN = 1'b1;
        #2;
        resetN = 1'b0;
        #1;
        model_reset();
        checkOutput();
        check("reset_count", 32'(count0), 32'h12);
        @(negedge clk);
        resetN = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].loadN, vecs[i].data, vecs[i].start, vecs[i].tick,
                          vecs[i].run_en, vecs[i].dir);
            step_clock();
            check($sformatf("vec%0d_count", i), 32'(count0), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_done", i),  32'(dp0),    32'(vecs[i].exp_dp));
            check($sformatf("vec%0d_run", i),   32'(run0),   32'(vecs[i].exp_run));
        end

        // Asynchronous reset in the middle of a count.
        applyStimulus(1, 8'h00, 0, 1, 1, 0);
        step_clock();
        #1;
        resetN = 1'b0;
        #1;
        model_reset();
        check("midreset_count", 32'(count0), 32'h12);
        check("midreset_run",   32'(run0),   32'h0);
        check("midreset_done",  32'(dp0),    32'h0);
        checkOutput();
        @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_clock();
            check("postreset_done", 32'(dp0), 32'h0);
        end

        // Wrap from 00 to 99 on the wrapping instance.
        applyStimulus(0, 8'h01, 0, 0, 1, 0); step_clock();
        applyStimulus(1, 8'h00, 1, 0, 1, 0); step_clock();
        applyStimulus(1, 8'h00, 0, 1, 1, 0); step_clock();
        check("wrap_count00", 32'(count1), 32'h00);
        check("wrap_done00",  32'(dp1),    32'h1);
        check("wrap_run00",   32'(run1),   32'h1);
        step_clock();
        check("wrap_count99", 32'(count1), 32'h99);
        check("wrap_done99",  32'(dp1),    32'h0);
        check("wrap_run99",   32'(run1),   32'h1);

        // Starting at terminal goes to DONE without a tick.
        applyStimulus(0, 8'h00, 0, 0, 1, 0); step_clock();
        applyStimulus(1, 8'h00, 1, 0, 1, 0); step_clock();
        check("entry_run", 32'(run0), 32'h1);
        applyStimulus(1, 8'h00, 0, 0, 1, 0); step_clock();
        check("entry_done_state", 32'(run0),   32'h0);
        check("entry_count",      32'(count0), 32'h00);

`ifdef BCD_TIMER_WARN_EN
        applyStimulus(0, 8'h05, 0, 0, 1, 0); step_clock();
        applyStimulus(1, 8'h00, 1, 0, 1, 0); step_clock();
        applyStimulus(1, 8'h00, 0, 1, 1, 0); step_clock();
        step_clock();
        check("warn_at03", 32'(warn0), 32'h0);
        applyStimulus(1, 8'h00, 0, 0, 1, 0); step_clock();
        check("warn_after03", 32'(warn0), 32'h1);
`endif

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 19) != 0), 8'($urandom_range(0, 255)),
                          ($urandom_range(0, 4) == 0), $urandom_range(0, 1) == 1,
                          ($urandom_range(0, 4) != 0),
                          ($urandom_range(0, 9) == 0) ? ~dir : dir);
            step_clock();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
